// File: rtl/ldm_writeback_seq.sv
// rtl/ldm_writeback_seq.sv - load-multiple register file write-back sequencer
module ldm_writeback_seq #(
   parameter int DATA_W = 32,
   parameter int NREG   = 16,
   localparam int AW    = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NREG-1:0]   reg_list,
   input  logic [DATA_W-1:0] base_in,
   input  logic              wb_base,
   input  logic [AW-1:0]     base_reg,
   output logic              mem_req,
   output logic [DATA_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_data,
   output logic              wen_ARd,
   output logic [AW-1:0]     ARd,
   output logic [DATA_W-1:0] Rd_data,
   output logic              pc_written,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WBB  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [NREG-1:0]   list_q;
   logic [NREG-1:0]   rem_q;
   logic [NREG-1:0]   rem_clr;
   logic [DATA_W-1:0] addr_q;
   logic              wb_q;
   logic [AW-1:0]     base_reg_q;
   logic [AW-1:0]     cur_idx;

   // Lowest set bit of the remaining list selects the register being loaded.
   always_comb begin
      cur_idx = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (rem_q[i]) cur_idx = AW'(i);
      end
   end

   assign rem_clr = rem_q & ~(NREG'(1) << cur_idx);

   // Next state and all outputs; addr_q already equals base + 4*count when WBB runs.
   always_comb begin
      state_nx   = state;
      mem_req    = 1'b0;
      wen_ARd    = 1'b0;
      ARd        = '0;
      Rd_data    = '0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nx = (reg_list != '0) ? S_REQ : S_DONE;
         end
         S_REQ: begin
            busy    = 1'b1;
            mem_req = 1'b1;
            if (mem_rvalid) begin
               wen_ARd = 1'b1;
               ARd     = cur_idx;
               Rd_data = mem_data;
               if (rem_clr == '0)
                  state_nx = (wb_q && !list_q[base_reg_q]) ? S_WBB : S_DONE;
            end
         end
         S_WBB: begin
            busy     = 1'b1;
            wen_ARd  = 1'b1;
            ARd      = base_reg_q;
            Rd_data  = addr_q;
            state_nx = S_DONE;
         end
         S_DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      mem_addr   = mem_req ? addr_q : '0;
      pc_written = wen_ARd && (ARd == AW'(NREG - 1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Capture the request in IDLE; retire one list bit and advance the address per accepted read.
   always_ff @(posedge clk) begin
      if (rst) begin
         list_q     <= '0;
         rem_q      <= '0;
         addr_q     <= '0;
         wb_q       <= 1'b0;
         base_reg_q <= '0;
      end else if (state == S_IDLE && start) begin
         list_q     <= reg_list;
         rem_q      <= reg_list;
         addr_q     <= base_in;
         wb_q       <= wb_base;
         base_reg_q <= base_reg;
      end else if (state == S_REQ && mem_rvalid) begin
         rem_q  <= rem_clr;
         addr_q <= addr_q + DATA_W'(4);
      end
   end

endmodule

// File: tb/tb_ldm_writeback_seq.sv
// tb/tb_ldm_writeback_seq.sv - randomized self-checking bench for ldm_writeback_seq
module tb_ldm_writeback_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] reg_list;
   logic [31:0] base_in;
   logic        wb_base;
   logic [3:0]  base_reg;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_rvalid;
   logic [31:0] mem_data;
   logic        wen_ARd;
   logic [3:0]  ARd;
   logic [31:0] Rd_data;
   logic        pc_written;
   logic        busy;
   logic        done;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] key;

   ldm_writeback_seq #(.DATA_W(32), .NREG(16)) dut (
      .clk(clk), .rst(rst), .start(start), .reg_list(reg_list), .base_in(base_in),
      .wb_base(wb_base), .base_reg(base_reg), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rvalid(mem_rvalid), .mem_data(mem_data), .wen_ARd(wen_ARd), .ARd(ARd),
      .Rd_data(Rd_data), .pc_written(pc_written), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check_val({tag, "_req"},  32'(mem_req), 32'd0);
      check_val({tag, "_addr"}, mem_addr, 32'd0);
      check_val({tag, "_wen"},  32'(wen_ARd), 32'd0);
      check_val({tag, "_ard"},  32'(ARd), 32'd0);
      check_val({tag, "_data"}, Rd_data, 32'd0);
      check_val({tag, "_pc"},   32'(pc_written), 32'd0);
      check_val({tag, "_busy"}, 32'(busy), 32'd0);
      check_val({tag, "_done"}, 32'(done), 32'd0);
   endtask

   // Memory returns addr ^ key. mode 0: no waits, 1: random waits, 2: first transfer withheld 3 cycles.
   // Called in an idle cycle (just after a rising edge); returns in the first idle cycle after done.
   task automatic run_txn(input logic [15:0] list, input logic [31:0] base, input logic wb,
                          input logic [3:0] breg, input int mode, input logic poke);
      int          q_idx[$];
      int          n, wr, waits, done_c, c;
      bit          wbf, wbb_done, fin, pend, rv, exp_wen;
      logic [31:0] ea, exp_ard, exp_data;
      q_idx.delete();
      for (int i = 0; i < 16; i++) if (list[i]) q_idx.push_back(i);
      n        = q_idx.size();
      wbf      = wb && (n > 0) && !list[breg];
      wr       = 0;
      waits    = 0;
      wbb_done = 0;
      fin      = 0;
      done_c   = 0;
      start    = 1'b1;
      reg_list = list;
      base_in  = base;
      wb_base  = wb;
      base_reg = breg;
      mem_rvalid = 1'b0;
      @(posedge clk); #1;
      reg_list = 16'($urandom);
      base_in  = $urandom;
      wb_base  = 1'($urandom);
      base_reg = 4'($urandom);
      for (c = 1; c <= 300 && !fin; c++) begin
         pend = (wr < n);
         ea   = base + 32'(4 * wr);
         case (mode)
            0:       rv = 1'b1;
            1:       rv = ($urandom_range(0, 3) != 0);
            default: rv = !(wr == 0 && waits < 3);
         endcase
         mem_rvalid = rv;
         mem_data   = mem_addr ^ key;
         if (poke && c == 1) begin
            start    = 1'b1;
            reg_list = 16'hFFFF;
         end else begin
            start    = 1'b0;
         end
         @(negedge clk);
         exp_wen  = pend ? rv : (wbf && !wbb_done);
         exp_ard  = !exp_wen ? 32'd0 : (pend ? 32'(q_idx[wr]) : 32'(breg));
         exp_data = !exp_wen ? 32'd0 : (pend ? (ea ^ key) : ea);
         check_val("mem_req", 32'(mem_req), 32'(pend));
         if (pend) check_val("mem_addr", mem_addr, ea);
         check_val("wen", 32'(wen_ARd), 32'(exp_wen));
         check_val("ard", 32'(ARd), exp_ard);
         check_val("rd_data", Rd_data, exp_data);
         check_val("pc_written", 32'(pc_written), 32'(exp_wen && exp_ard == 32'd15));
         check_val("busy", 32'(busy), 32'd1);
         check_val("done", 32'(done), 32'(!pend && !(wbf && !wbb_done)));
         if (pend && rv)                wr++;
         else if (pend)                 waits++;
         else if (wbf && !wbb_done)     wbb_done = 1;
         else begin fin = 1; done_c = c; end
         @(posedge clk); #1;
      end
      start = 1'b0;
      mem_rvalid = 1'b0;
      if (!fin) check_val("timeout", 32'd0, 32'd1);
      check_val("done_cycle", 32'(done_c), 32'(n + waits + (wbf ? 1 : 0) + 1));
      check_val("busy_after", 32'(busy), 32'd0);
      check_val("req_after", 32'(mem_req), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; reg_list = '0; base_in = '0; wb_base = 1'b0; base_reg = '0;
      mem_rvalid = 1'b1; mem_data = 32'hDEAD_BEEF; key = '0;
      repeat (2) @(posedge clk);
      #1;
      check_quiet("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      run_txn(16'h0006, 32'h0000_0100, 1'b0, 4'd0, 0, 1'b0);
      run_txn(16'h8001, 32'h0000_0020, 1'b1, 4'd13, 0, 1'b0);
      key = 32'h5A5A_0F0F;
      run_txn(16'h0C21, 32'h0000_1000, 1'b0, 4'd0, 2, 1'b0);
      run_txn(16'h0010, 32'h0000_0040, 1'b1, 4'd4, 0, 1'b0);
      run_txn(16'h0000, 32'h0000_0080, 1'b1, 4'd2, 0, 1'b0);
      run_txn(16'h0203, 32'h0000_0300, 1'b1, 4'd7, 1, 1'b1);
      run_txn(16'hFFFF, 32'hFFFF_FFF0, 1'b0, 4'd0, 1, 1'b0);
      run_txn(16'h7FFE, 32'hFFFF_FFFC, 1'b1, 4'd0, 0, 1'b0);

      // Reset after the first write of a 4-register list.
      start = 1'b1; reg_list = 16'h00F0; base_in = 32'h400; wb_base = 1'b1; base_reg = 4'd1;
      mem_rvalid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      mem_rvalid = 1'b1; mem_data = mem_addr ^ key;
      @(negedge clk);
      check_val("rst_first_wen", 32'(wen_ARd), 32'd1);
      check_val("rst_first_ard", 32'(ARd), 32'd4);
      @(posedge clk); #1;
      rst = 1'b1; mem_rvalid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; mem_rvalid = 1'b1; mem_data = 32'h1234_5678;
      @(negedge clk);
      check_quiet("after_rst");
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check_val("idle_wen", 32'(wen_ARd), 32'd0);
         check_val("idle_req", 32'(mem_req), 32'd0);
      end
      @(posedge clk); #1;
      run_txn(16'h0102, 32'h0000_0800, 1'b1, 4'd3, 0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         logic [15:0] l;
         key = $urandom;
         l = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         run_txn(l, $urandom & 32'hFFFF_FFFC, 1'($urandom), 4'($urandom),
                 int'($urandom_range(0, 2)), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
